// File: rtl/dance_ram_loader.sv
// Write-side front end for the sprite RAM: unpacks 16-pixel words onto the
// one-pixel-per-clock RAM write port and provides a bulk clear.
module dance_ram_loader #(
    parameter int         ADDR     = 10,
    parameter logic [1:0] CLR_CODE = 2'b00
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [ADDR-5:0] s_waddr,
    input  logic [31:0]     s_data,
    input  logic            clr_req,
    output logic            busy,
    output logic            done_tick,
    output logic [15:0]     word_cnt,
    output logic            we,
    output logic [ADDR-1:0] addr_w,
    output logic [1:0]      pixel_in
);

    typedef enum logic [1:0] {IDLE, SHIFT, CLEAR} state_t;

    localparam logic [ADDR-1:0] C_MAX = '1;

    state_t          state;
    logic [ADDR-5:0] waddr_h;
    logic [31:0]     data_h;
    logic [3:0]      k;
    logic [ADDR-1:0] c;
    logic            clr_last;

    // IDLE also waits out the trailing write cycle (busy) so a word held off
    // by a clear is accepted only once the clear has fully finished.
    always_comb begin
        s_ready = 1'b0;
        if (reset_n) begin
            case (state)
                IDLE:    s_ready = ~clr_req & ~busy;
                SHIFT:   s_ready = (k == 4'hF);
                default: s_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            we        <= 1'b0;
            addr_w    <= '0;
            pixel_in  <= 2'b00;
            busy      <= 1'b0;
            done_tick <= 1'b0;
            word_cnt  <= 16'd0;
            k         <= 4'd0;
            c         <= '0;
            waddr_h   <= '0;
            data_h    <= 32'd0;
            clr_last  <= 1'b0;
        end else begin
            we        <= 1'b0;
            busy      <= 1'b0;
            clr_last  <= 1'b0;
            done_tick <= clr_last;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        c     <= '0;
                        state <= CLEAR;
                    end else if (s_valid && s_ready) begin
                        waddr_h <= s_waddr;
                        data_h  <= s_data;
                        k       <= 4'd0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    we       <= 1'b1;
                    busy     <= 1'b1;
                    addr_w   <= {waddr_h, k};
                    pixel_in <= data_h[{k, 1'b0} +: 2];
                    k        <= k + 4'd1;
                    if (k == 4'hF) begin
                        if (word_cnt != 16'hFFFF) begin
                            word_cnt <= word_cnt + 16'd1;
                        end
                        // Latching the next word here keeps the write stream gap-free.
                        if (s_valid) begin
                            waddr_h <= s_waddr;
                            data_h  <= s_data;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                CLEAR: begin
                    we       <= 1'b1;
                    busy     <= 1'b1;
                    addr_w   <= c;
                    pixel_in <= CLR_CODE;
                    c        <= c + 1'b1;
                    if (c == C_MAX) begin
                        clr_last <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dance_ram_loader.sv
// Bench for dance_ram_loader: random words and clears checked against a queue
// of expected (address, pixel) writes built directly from the pixel-packing rules.
module tb_dance_ram_loader;

    localparam int ADDR = 10;
    localparam int WA   = ADDR - 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [WA-1:0]   s_waddr = '0;
    logic [31:0]     s_data = 32'd0;
    logic            clr_req = 1'b0;
    logic            busy;
    logic            done_tick;
    logic [15:0]     word_cnt;
    logic            we;
    logic [ADDR-1:0] addr_w;
    logic [1:0]      pixel_in;

    int total = 0;
    int bad   = 0;

    logic [ADDR+1:0] wr_q[$];
    logic [ADDR+1:0] exp_q[$];
    bit we_log[$], rdy_log[$], busy_log[$], done_log[$], hs_log[$];

    always #5 clk = ~clk;

    dance_ram_loader #(.ADDR(ADDR), .CLR_CODE(2'b00)) dut (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_waddr(s_waddr), .s_data(s_data), .clr_req(clr_req), .busy(busy),
        .done_tick(done_tick), .word_cnt(word_cnt), .we(we), .addr_w(addr_w),
        .pixel_in(pixel_in)
    );

    task automatic clear_logs();
        wr_q.delete(); exp_q.delete();
        we_log.delete(); rdy_log.delete(); busy_log.delete();
        done_log.delete(); hs_log.delete();
    endtask

    // Log index j: handshake/ready just before edge j, registered outputs just after it.
    task automatic step();
        #2;
        hs_log.push_back(s_valid === 1'b1 && s_ready === 1'b1);
        rdy_log.push_back(s_ready === 1'b1);
        @(posedge clk);
        #1;
        we_log.push_back(we === 1'b1);
        busy_log.push_back(busy === 1'b1);
        done_log.push_back(done_tick === 1'b1);
        if (we === 1'b1) wr_q.push_back({addr_w, pixel_in});
    endtask

    task automatic model_word(input logic [WA-1:0] a, input logic [31:0] d);
        for (int p = 0; p < 16; p++) exp_q.push_back({a, 4'(p), d[2*p +: 2]});
    endtask

    task automatic model_clear();
        for (int i = 0; i < (1 << ADDR); i++) exp_q.push_back({ADDR'(i), 2'b00});
    endtask

    function automatic int count_diff();
        int n;
        n = 0;
        if (wr_q.size() != exp_q.size()) return -1;
        for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    function automatic int count_bits(input int which, input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++) begin
            if (which == 0 && i < we_log.size()   && we_log[i])   n++;
            if (which == 1 && i < rdy_log.size()  && rdy_log[i])  n++;
            if (which == 2 && i < busy_log.size() && busy_log[i]) n++;
            if (which == 3 && i < done_log.size() && done_log[i]) n++;
        end
        return n;
    endfunction

    task automatic send(input logic [WA-1:0] a, input logic [31:0] d, input bit drop,
                        input int bound, output int hs_idx);
        s_valid = 1'b1; s_waddr = a; s_data = d; hs_idx = -1;
        for (int i = 0; i < bound && hs_idx < 0; i++) begin
            step();
            if (hs_log[hs_log.size()-1]) hs_idx = hs_log.size() - 1;
        end
        if (drop) s_valid = 1'b0;
    endtask

    task automatic test_reset();
        clear_logs();
        reset_n = 1'b0; s_valid = 1'b1; s_data = $urandom;
        step(); step();
        total++; if (we !== 1'b0)        begin bad++; $display("[TB] FAIL reset_we: got %b want 0", we); end
        total++; if (s_ready !== 1'b0)   begin bad++; $display("[TB] FAIL reset_ready: got %b want 0", s_ready); end
        total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        total++; if (word_cnt !== 16'd0) begin bad++; $display("[TB] FAIL reset_cnt: got %0d want 0", word_cnt); end
        total++; if (addr_w !== '0 || pixel_in !== 2'b00 || done_tick !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_regs: addr %h pix %b done %b want 0", addr_w, pixel_in, done_tick);
        end
        reset_n = 1'b1; s_valid = 1'b0;
        step();
        total++; if (!rdy_log[rdy_log.size()-1]) begin bad++; $display("[TB] FAIL release_ready: got 0 want 1"); end
    endtask

    task automatic test_single_word();
        logic [WA-1:0] a;
        logic [31:0]   d;
        int hs, nd;
        logic [15:0] cnt0;
        for (int w = 0; w < 4; w++) begin
            a = (w == 0) ? WA'(6'h03) : WA'($urandom_range(0, 63));
            d = (w == 0) ? 32'hE4E4_E4E4 : $urandom;
            clear_logs(); cnt0 = word_cnt;
            model_word(a, d);
            send(a, d, 1'b1, 60, hs);
            repeat (20) step();
            total++; if (hs < 0) begin bad++; $display("[TB] FAIL single_accept w%0d: no handshake, want one", w); end
            nd = count_diff();
            total++; if (nd != 0) begin
                bad++; $display("[TB] FAIL single_data w%0d: %0d writes (%0d wrong), want 16 (0 wrong)", w, wr_q.size(), nd);
            end
            total++; if (we_log[hs] || !we_log[hs+1]) begin
                bad++; $display("[TB] FAIL single_latency w%0d: we at hs=%b hs+1=%b, want 0,1", w, we_log[hs], we_log[hs+1]);
            end
            total++; if (count_bits(0, hs+1, hs+16) != 16 || count_bits(2, 0, busy_log.size()-1) != 16) begin
                bad++; $display("[TB] FAIL single_busy w%0d: we run %0d busy %0d, want 16/16", w,
                                count_bits(0, hs+1, hs+16), count_bits(2, 0, busy_log.size()-1));
            end
            total++; if (word_cnt !== cnt0 + 16'd1) begin
                bad++; $display("[TB] FAIL single_cnt w%0d: got %0d want %0d", w, word_cnt, cnt0 + 16'd1);
            end
            total++; if (busy !== 1'b0 || s_ready !== 1'b1) begin
                bad++; $display("[TB] FAIL single_idle w%0d: busy %b ready %b, want 0/1", w, busy, s_ready);
            end
        end
    endtask

    task automatic test_streaming();
        logic [WA-1:0] a[3];
        logic [31:0]   d[3];
        int hs[3];
        int n, nd, gaps;
        logic [15:0] cnt0;
        for (int run = 0; run < 2; run++) begin
            n = (run == 0) ? 2 : 3;
            if (run == 0) begin
                a[0] = WA'(6'h00); d[0] = 32'hFFFF_FFFF;
                a[1] = WA'(6'h3F); d[1] = 32'h5555_5555;
            end else begin
                for (int i = 0; i < 3; i++) begin a[i] = WA'($urandom_range(0, 63)); d[i] = $urandom; end
            end
            clear_logs(); cnt0 = word_cnt;
            for (int i = 0; i < n; i++) begin
                model_word(a[i], d[i]);
                send(a[i], d[i], i == n - 1, 60, hs[i]);
            end
            repeat (20) step();
            nd = count_diff();
            total++; if (nd != 0) begin
                bad++; $display("[TB] FAIL stream_data r%0d: %0d writes (%0d wrong), want %0d", run, wr_q.size(), nd, 16*n);
            end
            gaps = 0;
            for (int i = 1; i < n; i++) if (hs[i] - hs[i-1] != 16) gaps++;
            total++; if (gaps != 0 || hs[0] < 0) begin
                bad++; $display("[TB] FAIL stream_spacing r%0d: %0d bad handshake spacings, want 0", run, gaps);
            end
            total++; if (count_bits(0, hs[0]+1, hs[0]+16*n) != 16*n) begin
                bad++; $display("[TB] FAIL stream_gapless r%0d: got %0d we cycles want %0d", run,
                                count_bits(0, hs[0]+1, hs[0]+16*n), 16*n);
            end
            total++; if (count_bits(1, hs[0]+1, hs[n-1]) != n - 1) begin
                bad++; $display("[TB] FAIL stream_ready r%0d: ready cycles %0d want %0d", run,
                                count_bits(1, hs[0]+1, hs[n-1]), n - 1);
            end
            total++; if (word_cnt !== cnt0 + 16'(n)) begin
                bad++; $display("[TB] FAIL stream_cnt r%0d: got %0d want %0d", run, word_cnt, cnt0 + 16'(n));
            end
        end
    endtask

    task automatic test_clear();
        int di, lw, nd;
        clear_logs(); model_clear();
        clr_req = 1'b1; step(); clr_req = 1'b0;
        di = -1;
        for (int i = 0; i < 1100 && di < 0; i++) begin
            step();
            if (done_log[done_log.size()-1]) di = done_log.size() - 1;
        end
        repeat (5) step();
        lw = -1;
        for (int i = 0; i < we_log.size(); i++) if (we_log[i]) lw = i;
        nd = count_diff();
        total++; if (nd != 0) begin bad++; $display("[TB] FAIL clear_data: %0d writes (%0d wrong), want 1024", wr_q.size(), nd); end
        total++; if (di < 0 || di != lw + 1 || count_bits(3, 0, done_log.size()-1) != 1) begin
            bad++; $display("[TB] FAIL clear_done: done at %0d (count %0d), last write %0d, want single pulse at last+1",
                            di, count_bits(3, 0, done_log.size()-1), lw);
        end
        total++; if (count_bits(2, 0, busy_log.size()-1) != 1024) begin
            bad++; $display("[TB] FAIL clear_busy: got %0d busy cycles want 1024", count_bits(2, 0, busy_log.size()-1));
        end
        total++; if (count_bits(1, 0, di) != 0) begin
            bad++; $display("[TB] FAIL clear_ready: ready high %0d cycles during clear, want 0", count_bits(1, 0, di));
        end
    endtask

    task automatic test_collisions();
        logic [WA-1:0] a;
        logic [31:0]   d;
        int hs, nd, di;
        logic [15:0] cnt0;
        clear_logs();
        a = WA'($urandom_range(0, 63)); d = $urandom;
        model_word(a, d);
        send(a, d, 1'b1, 60, hs);
        repeat (4) step();
        clr_req = 1'b1; repeat (3) step(); clr_req = 1'b0;
        repeat (30) step();
        nd = count_diff();
        total++; if (nd != 0 || count_bits(3, 0, done_log.size()-1) != 0) begin
            bad++; $display("[TB] FAIL collide_shift: %0d writes (%0d wrong), %0d done pulses, want 16/0/0",
                            wr_q.size(), nd, count_bits(3, 0, done_log.size()-1));
        end

        clear_logs(); cnt0 = word_cnt;
        a = WA'($urandom_range(0, 63)); d = $urandom;
        model_clear(); model_word(a, d);
        s_valid = 1'b1; s_waddr = a; s_data = d; clr_req = 1'b1;
        step(); clr_req = 1'b0;
        send(a, d, 1'b1, 1200, hs);
        repeat (20) step();
        di = -1;
        for (int i = 0; i < done_log.size(); i++) if (done_log[i]) di = i;
        nd = count_diff();
        total++; if (hs_log[0]) begin bad++; $display("[TB] FAIL collide_priority: word taken with clr_req, want held off"); end
        total++; if (nd != 0) begin
            bad++; $display("[TB] FAIL collide_data: %0d writes (%0d wrong), want 1040 (0 wrong)", wr_q.size(), nd);
        end
        total++; if (di < 0 || hs != di + 1) begin
            bad++; $display("[TB] FAIL collide_order: accepted at %0d, done at %0d, want accept = done+1", hs, di);
        end
        total++; if (word_cnt !== cnt0 + 16'd1) begin
            bad++; $display("[TB] FAIL collide_cnt: got %0d want %0d", word_cnt, cnt0 + 16'd1);
        end
    endtask

    task automatic test_reset_mid();
        logic [WA-1:0] a;
        logic [31:0]   d;
        int hs, nd;
        clear_logs();
        a = WA'($urandom_range(0, 63)); d = $urandom;
        send(a, d, 1'b1, 60, hs);
        repeat (8) step();
        total++; if (wr_q.size() != 8 || pixel_in !== d[15:14]) begin
            bad++; $display("[TB] FAIL midreset_pre: %0d writes, pixel %b, want 8 writes, pixel %b", wr_q.size(), pixel_in, d[15:14]);
        end
        reset_n = 1'b0; step();
        total++; if (we !== 1'b0 || busy !== 1'b0 || word_cnt !== 16'd0) begin
            bad++; $display("[TB] FAIL midreset_abort: we %b busy %b cnt %0d, want 0/0/0", we, busy, word_cnt);
        end
        reset_n = 1'b1; step();
        clear_logs();
        a = WA'($urandom_range(0, 63)); d = $urandom;
        model_word(a, d);
        send(a, d, 1'b1, 60, hs);
        repeat (20) step();
        nd = count_diff();
        total++; if (nd != 0 || word_cnt !== 16'd1) begin
            bad++; $display("[TB] FAIL midreset_resume: %0d writes (%0d wrong), cnt %0d, want 16/0/1", wr_q.size(), nd, word_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_streaming();
        test_clear();
        test_collisions();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
